// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream valid/ready/data and downstream valid/ready/data.
// DATA_W must match the DATA_W of the pipe_stage_buf instance it connects to.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Environment side: drives upstream payload and downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side: accepts upstream payload and presents it downstream.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage: MODE 0 is a single register slice, MODE 1 a two-entry skid buffer with a
// registered in_ready. Also counts backpressure cycles (saturating) and supports a sync flush.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int MODE   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cnt_clr,
  pipe_stage_buf_if.slave  bus,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] bp_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BP_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  bp_cnt_q, bp_cnt_d;

  logic in_xfer_s;
  logic out_xfer_s;

  // Flush masks both handshakes; MODE 1 readiness comes only from the registered skid state.
  assign bus.in_ready  = (MODE == 0) ? (!flush && ((occ_q == 2'd0) || bus.out_ready))
                                     : (!flush && in_ready_q);
  assign bus.out_valid = (occ_q != 2'd0) && !flush;
  assign bus.out_data  = main_q;
  assign occ           = occ_q;
  assign bp_cnt        = bp_cnt_q;

  assign in_xfer_s  = bus.in_valid && bus.in_ready;
  assign out_xfer_s = bus.out_valid && bus.out_ready;

  // Next-state, entry data and occupancy.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = {DATA_W{1'b0}};
      skid_d  = {DATA_W{1'b0}};
    end else if (MODE == 0) begin
      if (in_xfer_s) begin
        main_d  = bus.in_data;
        state_d = ST_ONE;
      end else if (out_xfer_s) begin
        state_d = ST_EMPTY;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_d  = bus.in_data;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && !out_xfer_s) begin
            skid_d  = bus.in_data;
            state_d = ST_FULL;
          end else if (in_xfer_s && out_xfer_s) begin
            main_d  = bus.in_data;
            state_d = ST_ONE;
          end else if (out_xfer_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer_s) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
    case (state_d)
      ST_EMPTY: occ_d = 2'd0;
      ST_ONE:   occ_d = 2'd1;
      ST_FULL:  occ_d = 2'd2;
      default:  occ_d = 2'd0;
    endcase
  end

  // Backpressure counter: clear wins, otherwise saturating increment on stalled valid.
  always_comb begin
    bp_cnt_d = bp_cnt_q;
    if (cnt_clr) begin
      bp_cnt_d = {CNT_W{1'b0}};
    end else if (bus.out_valid && !bus.out_ready && (bp_cnt_q != BP_MAX)) begin
      bp_cnt_d = bp_cnt_q + CNT_W'(1);
    end else begin
      bp_cnt_d = bp_cnt_q;
    end
  end

  // State and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= {DATA_W{1'b0}};
      skid_q     <= {DATA_W{1'b0}};
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
      bp_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
      bp_cnt_q   <= bp_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a MODE 1 instance (CNT_W=4) and a MODE 0 instance
// driven with hand-computed vectors.
module tb_pipe_stage_buf;

  logic clk;
  logic rst;
  logic flush1, clr1, flush0, clr0;
  logic [1:0]  occ1, occ0;
  logic [3:0]  bp1;
  logic [15:0] bp0;

  int n_checks;
  int n_errs;

  pipe_stage_buf_if #(.DATA_W(32)) b1 ();
  pipe_stage_buf_if #(.DATA_W(32)) b0 ();

  pipe_stage_buf #(.DATA_W(32), .MODE(1), .CNT_W(4)) u_m1 (
    .clk(clk), .rst(rst), .flush(flush1), .cnt_clr(clr1),
    .bus(b1), .occ(occ1), .bp_cnt(bp1)
  );

  pipe_stage_buf #(.DATA_W(32), .MODE(0), .CNT_W(16)) u_m0 (
    .clk(clk), .rst(rst), .flush(flush0), .cnt_clr(clr0),
    .bus(b0), .occ(occ0), .bp_cnt(bp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m0_din   [6];
  logic        m0_rdy   [6];
  logic        m0_irdy  [6];
  logic [31:0] m0_dout  [6];

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst = 1'b1;
    flush1 = 1'b0; clr1 = 1'b0; flush0 = 1'b0; clr0 = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = 32'h0; b1.out_ready = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = 32'h0; b0.out_ready = 1'b0;

    // Reset state
    #2;
    check_val("rst_occ1",   64'(occ1), 64'd0);
    check_val("rst_oval1",  64'(b1.out_valid), 64'd0);
    check_val("rst_odat1",  64'(b1.out_data), 64'd0);
    check_val("rst_bp1",    64'(bp1), 64'd0);
    check_val("rst_irdy1",  64'(b1.in_ready), 64'd1);
    check_val("rst_irdy0",  64'(b0.in_ready), 64'd1);
    check_val("rst_oval0",  64'(b0.out_valid), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_val("post_rst_irdy1", 64'(b1.in_ready), 64'd1);

    // MODE 1 streaming at full rate
    b1.out_ready = 1'b1;
    b1.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b1.in_data = 32'h10 + 32'(i);
      #1;
      check_val("stream_irdy", 64'(b1.in_ready), 64'd1);
      tick();
      check_val("stream_oval", 64'(b1.out_valid), 64'd1);
      check_val("stream_odat", 64'(b1.out_data), 64'h10 + 64'(i));
      check_val("stream_occ",  64'(occ1), 64'd1);
    end
    b1.in_valid = 1'b0;
    tick();
    check_val("stream_drain_occ", 64'(occ1), 64'd0);
    check_val("stream_bp",        64'(bp1), 64'd0);

    // MODE 1 fill to FULL, hold off third payload, then drain in order
    b1.out_ready = 1'b0;
    b1.in_valid  = 1'b1;
    b1.in_data   = 32'hA;
    tick();
    check_val("skid_a_occ",  64'(occ1), 64'd1);
    check_val("skid_a_irdy", 64'(b1.in_ready), 64'd1);
    b1.in_data = 32'hB;
    tick();
    check_val("skid_b_occ",  64'(occ1), 64'd2);
    check_val("skid_b_irdy", 64'(b1.in_ready), 64'd0);
    b1.in_data = 32'hC;
    tick();
    check_val("skid_c_held_occ", 64'(occ1), 64'd2);
    check_val("skid_out_a",      64'(b1.out_data), 64'hA);
    b1.out_ready = 1'b1;
    #1;
    check_val("skid_irdy_indep", 64'(b1.in_ready), 64'd0);
    tick();
    check_val("skid_out_b", 64'(b1.out_data), 64'hB);
    check_val("skid_occ1",  64'(occ1), 64'd1);
    tick();
    check_val("skid_out_c", 64'(b1.out_data), 64'hC);
    check_val("skid_occ_c", 64'(occ1), 64'd1);
    b1.in_valid = 1'b0;
    tick();
    check_val("skid_empty",  64'(occ1), 64'd0);
    check_val("skid_bp",     64'(bp1), 64'd2);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    check_val("skid_bp_clr", 64'(bp1), 64'd0);

    // MODE 1 flush while FULL
    b1.out_ready = 1'b0;
    b1.in_valid  = 1'b1;
    b1.in_data   = 32'h1;
    tick();
    b1.in_data = 32'h2;
    tick();
    check_val("fl_full_occ", 64'(occ1), 64'd2);
    flush1 = 1'b1;
    b1.in_data = 32'h3;
    #1;
    check_val("fl_oval_during", 64'(b1.out_valid), 64'd0);
    check_val("fl_irdy_during", 64'(b1.in_ready), 64'd0);
    tick();
    flush1 = 1'b0;
    b1.in_valid = 1'b0;
    #1;
    check_val("fl_occ_after",  64'(occ1), 64'd0);
    check_val("fl_odat_after", 64'(b1.out_data), 64'd0);
    check_val("fl_oval_after", 64'(b1.out_valid), 64'd0);
    check_val("fl_bp_kept",    64'(bp1), 64'd1);
    tick();
    check_val("fl_no_accept",  64'(occ1), 64'd0);

    // Backpressure counter saturation at 15 and clear priority
    b1.in_valid = 1'b1;
    b1.in_data  = 32'h77;
    tick();
    b1.in_valid = 1'b0;
    repeat (10) tick();
    check_val("bp_mid", 64'(bp1), 64'd11);
    repeat (10) tick();
    check_val("bp_sat",     64'(bp1), 64'd15);
    check_val("bp_hold_dat", 64'(b1.out_data), 64'h77);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    check_val("bp_clr_wins", 64'(bp1), 64'd0);
    tick();
    check_val("bp_restart", 64'(bp1), 64'd1);

    // Asynchronous reset pulse while FULL
    b1.in_valid = 1'b1;
    b1.in_data  = 32'h5A;
    tick();
    b1.in_valid = 1'b0;
    check_val("ar_full_occ", 64'(occ1), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check_val("ar_occ",  64'(occ1), 64'd0);
    check_val("ar_oval", 64'(b1.out_valid), 64'd0);
    check_val("ar_odat", 64'(b1.out_data), 64'd0);
    check_val("ar_bp",   64'(bp1), 64'd0);
    check_val("ar_irdy", 64'(b1.in_ready), 64'd1);
    #1;
    rst = 1'b0;
    b1.in_valid  = 1'b1;
    b1.in_data   = 32'h55;
    b1.out_ready = 1'b1;
    #1;
    check_val("ar_push_irdy", 64'(b1.in_ready), 64'd1);
    tick();
    b1.in_valid = 1'b0;
    check_val("ar_push_oval", 64'(b1.out_valid), 64'd1);
    check_val("ar_push_odat", 64'(b1.out_data), 64'h55);
    check_val("ar_push_occ",  64'(occ1), 64'd1);
    tick();
    check_val("ar_drain_occ", 64'(occ1), 64'd0);

    // MODE 0 with toggling out_ready and continuous input
    m0_din  = '{32'h20, 32'h21, 32'h21, 32'h21, 32'h22, 32'h22};
    m0_rdy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    m0_irdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    m0_dout = '{32'h20, 32'h20, 32'h21, 32'h21, 32'h22, 32'h22};
    b0.in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      b0.in_data   = m0_din[c];
      b0.out_ready = m0_rdy[c];
      #1;
      check_val("m0_irdy", 64'(b0.in_ready), 64'(m0_irdy[c]));
      tick();
      check_val("m0_oval", 64'(b0.out_valid), 64'd1);
      check_val("m0_odat", 64'(b0.out_data), 64'(m0_dout[c]));
      check_val("m0_occ",  64'(occ0), 64'd1);
    end
    check_val("m0_bp", 64'(bp0), 64'd3);
    b0.in_valid = 1'b0;
    flush0 = 1'b1;
    #1;
    check_val("m0_fl_irdy", 64'(b0.in_ready), 64'd0);
    check_val("m0_fl_oval", 64'(b0.out_valid), 64'd0);
    tick();
    flush0 = 1'b0;
    check_val("m0_fl_occ",  64'(occ0), 64'd0);
    check_val("m0_fl_odat", 64'(b0.out_data), 64'd0);
    check_val("m0_fl_bp",   64'(bp0), 64'd3);
    b0.out_ready = 1'b1;
    b0.in_valid  = 1'b1;
    b0.in_data   = 32'h33;
    tick();
    b0.in_valid = 1'b0;
    check_val("m0_lat1_odat", 64'(b0.out_data), 64'h33);
    tick();
    check_val("m0_out_only_oval", 64'(b0.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
